// File: rtl/arm_sb_pkg.sv
// Shared types for the posted-write store buffer: FSM states and the queued entry.
// The entry address field is sized for the widest supported word address.
package arm_sb_pkg;

  localparam int SB_AW_MAX = 32;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_HALTED
  } sb_state_t;

  typedef struct packed {
    logic [SB_AW_MAX-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

endpackage

// File: rtl/arm_store_buffer_if.sv
// Core-side (MEM stage) and memory-side bundles of the store buffer.
// master drives requests; slave answers them.
interface arm_sb_core_if #(parameter int AW = 30);
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic [3:0]    core_we;
  logic          core_rd;
  logic          core_halt;
  logic [31:0]   core_rdata;
  logic          core_stall;
  logic          halted;

  modport master (
    output core_addr, core_wdata, core_we, core_rd, core_halt,
    input  core_rdata, core_stall, halted
  );
  modport slave (
    input  core_addr, core_wdata, core_we, core_rd, core_halt,
    output core_rdata, core_stall, halted
  );
endinterface

interface arm_sb_mem_if #(parameter int AW = 30);
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_en;

  modport master (
    output mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_en,
    input  mem_rd_data, mem_wr_ready
  );
  modport slave (
    input  mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_en,
    output mem_rd_data, mem_wr_ready
  );
endinterface

// File: rtl/arm_sb_fifo.sv
// Store-buffer FIFO: DEPTH entries, wrapping head/tail pointers, occupancy count
// and a per-entry valid vector so the parent can address-match pending stores.
module arm_sb_fifo
  import arm_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  sb_entry_t                           push_entry,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output sb_entry_t                           head,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][SB_AW_MAX-1:0]     ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_ptr, tail_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[head_ptr];

  // Parent guarantees push only when !full and pop only when !empty,
  // so the set and clear below never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      ent_vld  <= '0;
    end else begin
      if (push) begin
        tail_ptr          <= tail_ptr + PW'(1);
        ent_vld[tail_ptr] <= 1'b1;
      end
      if (pop) begin
        head_ptr          <= head_ptr + PW'(1);
        ent_vld[head_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: ent_vld/count qualify every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_ptr] <= push_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_addr
    assign ent_addr[i] = mem_q[i].addr;
  end

endmodule

// File: rtl/arm_store_buffer.sv
// Posted-write buffer between MEM stage and data memory: queues stores, drains them
// over a valid/ready port, stalls loads that hit a pending store, drains fully on halt.
module arm_store_buffer
  import arm_sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst,
  arm_sb_core_if.slave  core,
  arm_sb_mem_if.master  mem
);

  sb_state_t                       state_q, state_d;
  sb_entry_t                       push_entry, head;
  logic                            store_req, push, pop, full, empty, hazard, stall;
  logic [DEPTH-1:0]                ent_vld, hit;
  logic [DEPTH-1:0][SB_AW_MAX-1:0] ent_addr;

  assign store_req  = |core.core_we;
  assign push_entry = '{addr: SB_AW_MAX'(core.core_addr),
                        data: core.core_wdata,
                        be:   core.core_we};

  // Whole-word match; stored addresses are zero-extended the same way as the probe.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_vld[i] && (ent_addr[i] == SB_AW_MAX'(core.core_addr));
  end
  assign hazard = |hit;

  arm_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .ent_vld    (ent_vld),
    .ent_addr   (ent_addr)
  );

  assign pop = mem.mem_wr_valid && mem.mem_wr_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SB_RUN;
    else     state_q <= state_d;
  end

  // A store takes priority over a same-cycle load; the load is simply ignored.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      SB_RUN: begin
        push  = store_req && !full;
        stall = store_req ? full : (core.core_rd && hazard);
        if (core.core_halt) state_d = SB_DRAIN;
      end
      SB_DRAIN: begin
        stall = store_req || (core.core_rd && hazard);
        if (empty) state_d = SB_HALTED;
      end
      SB_HALTED: begin
        state_d = SB_HALTED;
      end
      default: state_d = SB_RUN;
    endcase
    if (rst) begin
      push  = 1'b0;
      stall = 1'b0;
    end
  end

  assign core.core_stall = stall;
  assign core.core_rdata = mem.mem_rd_data;
  assign core.halted     = (state_q == SB_HALTED);

  assign mem.mem_rd_addr  = core.core_addr;
  assign mem.mem_wr_valid = !empty;
  assign mem.mem_wr_addr  = AW'(head.addr);
  assign mem.mem_wr_data  = head.data;
  assign mem.mem_wr_en    = head.be;

endmodule

// File: tb/tb_arm_store_buffer.sv
// Scoreboarded bench for arm_store_buffer: queue-based reference model predicts stalls,
// halt state and the exact memory write order; a separate monitor checks every write.
module tb_arm_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 30;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arm_sb_core_if #(.AW(AW)) cif ();
  arm_sb_mem_if  #(.AW(AW)) mif ();

  arm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (cif.slave),
    .mem  (mif.master)
  );

  function automatic logic [31:0] rd_fn(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a;
    return {t[15:0], ~t[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign mif.mem_rd_data = rd_fn(cif.core_addr);

  wr_t  pend_q[$];
  wr_t  exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_mode = 0;
  logic m_stall = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mif.mem_wr_valid === 1'b1 && mif.mem_wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_write: got write to %0h, expected none at %0t",
                 mif.mem_wr_addr, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", mif.mem_wr_addr, w.a);
        check("wr_data", mif.mem_wr_data, w.d);
        check("wr_en",   mif.mem_wr_en,   w.be);
      end
    end
  end

  // One core cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic rd, input logic halt, input logic rdy, input logic r);
    int   n;
    logic hz, es, acc;
    wr_t  w;
    cif.core_we    = we;
    cif.core_addr  = a;
    cif.core_wdata = d;
    cif.core_rd    = rd;
    cif.core_halt  = halt;
    mif.mem_wr_ready = rdy;
    rst = r;
    @(negedge clk);
    n  = pend_q.size();
    hz = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].a == a) hz = 1'b1;
    if (r || m_mode == 2) es = 1'b0;
    else if (we != 4'h0)  es = (m_mode == 1) || (n == DEPTH);
    else                  es = rd && hz;
    check("core_stall",   cif.core_stall,   es);
    check("mem_wr_valid", mif.mem_wr_valid, n != 0);
    check("halted",       cif.halted,       m_mode == 2);
    check("mem_rd_addr",  mif.mem_rd_addr,  a);
    if (rd && we == 4'h0 && !es) check("core_rdata", cif.core_rdata, rd_fn(a));
    if (n != 0) begin
      check("head_addr", mif.mem_wr_addr, pend_q[0].a);
      check("head_data", mif.mem_wr_data, pend_q[0].d);
      check("head_en",   mif.mem_wr_en,   pend_q[0].be);
    end
    acc = !r && m_mode == 0 && we != 4'h0 && n < DEPTH;
    w   = '{a: a, d: d, be: we};
    if (r) begin
      pend_q.delete();
      m_mode = 0;
    end else begin
      if (n != 0 && rdy) void'(pend_q.pop_front());
      if (acc) pend_q.push_back(w);
      if (m_mode == 0 && halt)        m_mode = 1;
      else if (m_mode == 1 && n == 0) m_mode = 2;
    end
    m_stall = es;
    @(posedge clk);
    if (r)        exp_q.delete();
    else if (acc) exp_q.push_back(w);
    #1;
  endtask

  task automatic idle(input logic rdy, input int cycles);
    for (int i = 0; i < cycles; i++) step(4'h0, AW'(0), 32'h0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [31:0] d, input logic rdy);
    step(4'hF, a, d, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Core holds a stalled store until the model says it went in.
  task automatic store_hold(input logic [AW-1:0] a, input logic [31:0] d, input logic rdy);
    int k;
    k = 0;
    do begin
      store(a, d, rdy);
      k++;
    end while (m_stall && k < 50);
    if (m_stall) begin
      n_chk++;
      n_fail++;
      $display("FAIL store_timeout: got stall after %0d cycles, expected acceptance", k);
    end
  endtask

  task automatic do_reset();
    step(4'h0, AW'(0), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'h0, AW'(0), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    cif.core_we = 4'h0; cif.core_addr = '0; cif.core_wdata = '0;
    cif.core_rd = 1'b0; cif.core_halt = 1'b0; mif.mem_wr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(1'b0, 2);

    // basic drain
    store(AW'('h10), 32'hDEADBEEF, 1'b1);
    idle(1'b1, 3);

    // full with ready low, then release
    for (int i = 1; i <= 4; i++) store(AW'(i), 32'hA000_0000 + i, 1'b0);
    store(AW'(5), 32'hA000_0005, 1'b0);
    store(AW'(5), 32'hA000_0005, 1'b0);
    store_hold(AW'(5), 32'hA000_0005, 1'b1);
    idle(1'b1, 6);

    // load hazard
    store(AW'('h20), 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h0, AW'('h20), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'h0, AW'('h21), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h0, AW'('h20), 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // push and pop together at count 2, across pointer wrap
    store(AW'('h30), 32'hB000_0000, 1'b0);
    store(AW'('h31), 32'hB000_0001, 1'b0);
    for (int i = 2; i < 10; i++) store(AW'('h30 + i), 32'hB000_0000 + i, 1'b1);
    idle(1'b1, 4);

    // halt with 3 pending
    for (int i = 0; i < 3; i++) store(AW'('h40 + i), 32'hC000_0000 + i, 1'b0);
    step(4'h0, AW'(0), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    store(AW'('h50), 32'hC0DE_0000, 1'b0);
    store(AW'('h50), 32'hC0DE_0000, 1'b1);
    idle(1'b1, 5);
    store(AW'('h51), 32'hC0DE_0001, 1'b1);
    step(4'h0, AW'('h41), 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // reset mid-drain
    do_reset();
    store(AW'('h60), 32'hD000_0000, 1'b0);
    store(AW'('h61), 32'hD000_0001, 1'b0);
    step(4'h0, AW'(0), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'h0, AW'(0), 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 5);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] we;
      we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(we, AW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0);
    end
    idle(1'b1, DEPTH + 3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
